// File: rtl/hip_int_rcv.sv
// HIP board-side interrupt receiver: sync, glitch filter, pending latch
// and fixed-priority REQ/ACK presentation of one source at a time.
module hip_int_rcv #(
    parameter int NUM_INT     = 8,
    parameter int FILT_CYCLES = 4
) (
    input  logic               RST_CPLD_CLK,
    input  logic               CPLD_RST,
    input  logic [NUM_INT-1:0] INT_IN_,
    input  logic [NUM_INT-1:0] INT_MASK,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic [2:0]         INT_VEC,
    output logic [NUM_INT-1:0] INT_PEND,
    output logic [NUM_INT-1:0] INT_OVR
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_REL
    } state_t;

    state_t state, state_n;

    // Levels kept in pin polarity: 1 = deasserted
    logic [NUM_INT-1:0] sync1, sync2, filt, filt_d;
    logic [3:0]         cnt [NUM_INT];

    logic [NUM_INT-1:0] rise, clr, live;
    logic [2:0]         pick, vec_n;

    always_ff @(posedge RST_CPLD_CLK or posedge CPLD_RST) begin
        if (CPLD_RST) begin
            sync1  <= '1;
            sync2  <= '1;
            filt   <= '1;
            filt_d <= '1;
            for (int i = 0; i < NUM_INT; i++) cnt[i] <= 4'd0;
        end else begin
            sync1  <= INT_IN_;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < NUM_INT; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= 4'd0;
                end else if (cnt[i] + 4'd1 == 4'(FILT_CYCLES)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= 4'd0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    assign rise = filt_d & ~filt;
    assign live = INT_PEND & ~INT_MASK;

    always_comb begin
        pick = 3'd0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (live[i]) pick = 3'(i);
        end
    end

    always_comb begin
        state_n = state;
        vec_n   = INT_VEC;
        clr     = '0;
        unique case (state)
            IDLE: begin
                if (|live) begin
                    state_n = REQ;
                    vec_n   = pick;
                end
            end
            REQ: begin
                if (INT_ACK) begin
                    state_n = WAIT_REL;
                    for (int i = 0; i < NUM_INT; i++) begin
                        clr[i] = (INT_VEC == 3'(i));
                    end
                end
            end
            WAIT_REL: begin
                if (!INT_ACK) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A new edge on a bit being acked keeps it pending but drops overrun
    always_ff @(posedge RST_CPLD_CLK or posedge CPLD_RST) begin
        if (CPLD_RST) begin
            state    <= IDLE;
            INT_REQ  <= 1'b0;
            INT_VEC  <= 3'd0;
            INT_PEND <= '0;
            INT_OVR  <= '0;
        end else begin
            state    <= state_n;
            INT_REQ  <= (state_n == REQ);
            INT_VEC  <= vec_n;
            INT_PEND <= (INT_PEND & ~clr) | rise;
            INT_OVR  <= (INT_OVR | (rise & INT_PEND)) & ~clr;
        end
    end

endmodule

// File: tb/tb_hip_int_rcv.sv
// Directed table-driven bench for hip_int_rcv with default parameters.
// Each row drives inputs, advances a number of clocks and checks outputs.
module tb_hip_int_rcv;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_n;
    logic [7:0] mask;
    logic       ack;
    logic       req;
    logic [2:0] vec;
    logic [7:0] pend;
    logic [7:0] ovr;

    int errs   = 0;
    int checks = 0;

    hip_int_rcv #(
        .NUM_INT    (8),
        .FILT_CYCLES(4)
    ) dut (
        .RST_CPLD_CLK(clk),
        .CPLD_RST    (rst),
        .INT_IN_     (in_n),
        .INT_MASK    (mask),
        .INT_ACK     (ack),
        .INT_REQ     (req),
        .INT_VEC     (vec),
        .INT_PEND    (pend),
        .INT_OVR     (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] in_n;
        logic [7:0] mask;
        logic       ack;
        int         cyc;
        logic       req;
        logic [2:0] vec;
        logic [7:0] pend;
        logic [7:0] ovr;
    } row_t;

    row_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic r,
                           input logic [2:0] v, input logic [7:0] p,
                           input logic [7:0] o);
        chk({nm, " req"}, 32'(req), 32'(r));
        chk({nm, " vec"}, 32'(vec), 32'(v));
        chk({nm, " pend"}, 32'(pend), 32'(p));
        chk({nm, " ovr"}, 32'(ovr), 32'(o));
    endtask

    task automatic add(input logic r, input logic [7:0] i,
                       input logic [7:0] m, input logic a, input int c,
                       input logic er, input logic [2:0] ev,
                       input logic [7:0] ep, input logic [7:0] eo);
        row_t x;
        x.rst  = r;
        x.in_n = i;
        x.mask = m;
        x.ack  = a;
        x.cyc  = c;
        x.req  = er;
        x.vec  = ev;
        x.pend = ep;
        x.ovr  = eo;
        tbl.push_back(x);
    endtask

    initial begin
        rst  = 1'b1;
        in_n = 8'hFF;
        mask = 8'h00;
        ack  = 1'b0;

        // reset with all lines low, then all pend, source 0 first
        add(1, 8'h00, 8'h00, 0, 2, 0, 0, 8'h00, 8'h00);
        add(0, 8'h00, 8'h00, 0, 6, 0, 0, 8'h00, 8'h00);
        add(0, 8'h00, 8'h00, 0, 1, 0, 0, 8'hFF, 8'h00);
        add(0, 8'h00, 8'h00, 0, 1, 1, 0, 8'hFF, 8'h00);
        add(0, 8'h00, 8'h00, 1, 1, 0, 0, 8'hFE, 8'h00);
        add(0, 8'h00, 8'h00, 0, 1, 0, 0, 8'hFE, 8'h00);
        add(0, 8'h00, 8'h00, 0, 1, 1, 1, 8'hFE, 8'h00);
        // 3-cycle glitch rejected, then a real 4+ cycle low on bit 3
        add(1, 8'hFF, 8'h00, 0, 2, 0, 0, 8'h00, 8'h00);
        add(0, 8'hF7, 8'h00, 0, 3, 0, 0, 8'h00, 8'h00);
        add(0, 8'hFF, 8'h00, 0, 8, 0, 0, 8'h00, 8'h00);
        add(0, 8'hF7, 8'h00, 0, 6, 0, 0, 8'h00, 8'h00);
        add(0, 8'hF7, 8'h00, 0, 1, 0, 0, 8'h08, 8'h00);
        add(0, 8'hF7, 8'h00, 0, 1, 1, 3, 8'h08, 8'h00);
        add(0, 8'hF7, 8'h00, 1, 1, 0, 3, 8'h00, 8'h00);
        add(0, 8'hF7, 8'h00, 0, 2, 0, 3, 8'h00, 8'h00);
        // priority under mask, unmask after pend, mask during REQ
        add(1, 8'hFF, 8'h04, 0, 2, 0, 0, 8'h00, 8'h00);
        add(0, 8'hDB, 8'h04, 0, 7, 0, 0, 8'h24, 8'h00);
        add(0, 8'hDB, 8'h04, 0, 1, 1, 5, 8'h24, 8'h00);
        add(0, 8'hDB, 8'h04, 1, 1, 0, 5, 8'h04, 8'h00);
        add(0, 8'hDB, 8'h00, 0, 1, 0, 5, 8'h04, 8'h00);
        add(0, 8'hDB, 8'h00, 0, 1, 1, 2, 8'h04, 8'h00);
        add(0, 8'hDB, 8'hFF, 0, 2, 1, 2, 8'h04, 8'h00);
        add(0, 8'hDB, 8'hFF, 1, 1, 0, 2, 8'h00, 8'h00);
        add(0, 8'hDB, 8'h00, 0, 2, 0, 2, 8'h00, 8'h00);
        // overrun on source 1, cleared by ack
        add(1, 8'hFF, 8'h00, 0, 2, 0, 0, 8'h00, 8'h00);
        add(0, 8'hFD, 8'h00, 0, 7, 0, 0, 8'h02, 8'h00);
        add(0, 8'hFD, 8'h00, 0, 1, 1, 1, 8'h02, 8'h00);
        add(0, 8'hFF, 8'h00, 0, 6, 1, 1, 8'h02, 8'h00);
        add(0, 8'hFD, 8'h00, 0, 6, 1, 1, 8'h02, 8'h00);
        add(0, 8'hFD, 8'h00, 0, 1, 1, 1, 8'h02, 8'h02);
        add(0, 8'hFD, 8'h00, 1, 1, 0, 1, 8'h00, 8'h00);
        add(0, 8'hFD, 8'h00, 0, 2, 0, 1, 8'h00, 8'h00);
        // long ack: one clear, re-request 2 edges after release
        add(1, 8'hFF, 8'h00, 0, 2, 0, 0, 8'h00, 8'h00);
        add(0, 8'hFC, 8'h00, 0, 8, 1, 0, 8'h03, 8'h00);
        add(0, 8'hFC, 8'h00, 1, 1, 0, 0, 8'h02, 8'h00);
        add(0, 8'hFC, 8'h00, 1, 4, 0, 0, 8'h02, 8'h00);
        add(0, 8'hFC, 8'h00, 0, 1, 0, 0, 8'h02, 8'h00);
        add(0, 8'hFC, 8'h00, 0, 1, 1, 1, 8'h02, 8'h00);

        for (int k = 0; k < tbl.size(); k++) begin
            rst  = tbl[k].rst;
            in_n = tbl[k].in_n;
            mask = tbl[k].mask;
            ack  = tbl[k].ack;
            repeat (tbl[k].cyc) @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", k), tbl[k].req, tbl[k].vec,
                    tbl[k].pend, tbl[k].ovr);
        end

        // asynchronous reset in the middle of a request
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 3'd0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        in_n = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_all("post_rst", 1'b0, 3'd0, 8'h00, 8'h00);
        in_n = 8'hFE;
        repeat (7) @(posedge clk);
        #1;
        chk_all("rst_pend", 1'b0, 3'd0, 8'h01, 8'h00);
        @(posedge clk);
        #1;
        chk_all("rst_idle_req", 1'b1, 3'd0, 8'h01, 8'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
